// File: rtl/param_memory_pkg.sv
// Shared definitions for param_memory: FSM state encoding, wait-counter sizing, and a clog2 helper.
package param_memory_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_W           = clog2(MAX_WAIT_STATES + 1);

endpackage

// File: rtl/param_memory_if.sv
// ce/rden/wren request bus with ready/err/busy completion, used between a register front-end and param_memory.
// The master holds ce high for the whole transaction; the slave returns a one-cycle ready pulse.
interface param_memory_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                      ce;
    logic                      rden;
    logic                      wren;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_strb;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      ready;
    logic                      err;
    logic                      busy;

    modport master (
        output ce, rden, wren, addr, wr_data, wr_strb,
        input  rd_data, ready, err, busy
    );

    modport slave (
        input  ce, rden, wren, addr, wr_data, wr_strb,
        output rd_data, ready, err, busy
    );
endinterface

// File: rtl/param_memory_mem_array.sv
// Word storage with optional test-pattern contents, byte-strobed write port and registered read port.
// Write and read both take effect on the edge where i_we / i_re is high; no backpressure.
module mem_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int INIT_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);
    logic [DATA_WIDTH-1:0] w_words [DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Contents are set once at time zero and deliberately not touched by reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_WIDTH-1:0] r_word = (INIT_MODE == 1) ? DATA_WIDTH'(i) : '0;

        always_ff @(posedge clk) begin
            if (i_we && (i_addr == ADDR_WIDTH'(i))) begin
                for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                    if (i_wr_strb[k]) begin
                        r_word[8*k +: 8] <= i_wr_data[8*k +: 8];
                    end
                end
            end
        end

        assign w_words[i] = r_word;
    end

    // Addresses at or beyond DEPTH match no word and read back as zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_addr == ADDR_WIDTH'(i)) begin
                w_rd_word = w_words[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= w_rd_word;
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/param_memory.sv
// Parameterised single-port memory: request accept, WAIT_STATES wait cycles, one-cycle ready/err response.
// Latency WAIT_STATES+1 cycles; no request accepted while busy; dropping ce mid-transaction aborts it.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int INIT_MODE   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    param_memory_if.slave bus
);
    localparam int                NB      = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0]  WS_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NB-1:0]         r_wr_strb;
    logic                  r_is_rd;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_is_rd;
    logic                  w_oor;
    logic                  w_we;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NB-1:0]         w_wr_strb;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_accept = (r_state == ST_IDLE) && bus.ce && (bus.rden || bus.wren);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (!bus.ce)            w_next_state = ST_IDLE;
                else if (r_cnt == '0)   w_next_state = ST_RESP;
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (r_state != ST_IDLE);
        bus.ready   = (r_state == ST_RESP);
        bus.err     = r_err;
        bus.rd_data = w_rd_data;
    end

    // With zero wait states the commit lands on the accept edge, before the capture registers load.
    assign w_is_rd   = (r_state == ST_IDLE) ? bus.rden    : r_is_rd;
    assign w_addr    = (r_state == ST_IDLE) ? bus.addr    : r_addr;
    assign w_wr_data = (r_state == ST_IDLE) ? bus.wr_data : r_wr_data;
    assign w_wr_strb = (r_state == ST_IDLE) ? bus.wr_strb : r_wr_strb;

    assign w_commit = (w_next_state == ST_RESP);
    assign w_oor    = ({1'b0, w_addr} >= DEPTH_L);
    assign w_re     = w_commit && w_is_rd;
    assign w_we     = w_commit && !w_is_rd && !w_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
            r_is_rd   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_commit && w_oor;
            if (w_accept) begin
                r_addr    <= bus.addr;
                r_wr_data <= bus.wr_data;
                r_wr_strb <= bus.wr_strb;
                r_is_rd   <= bus.rden;
                r_cnt     <= WS_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_MODE  (INIT_MODE)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_re      (w_re),
        .i_addr    (w_addr),
        .i_wr_data (w_wr_data),
        .i_wr_strb (w_wr_strb),
        .o_rd_data (w_rd_data)
    );
endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: three configurations driven from one shared request bus.
module tb_param_memory;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ce;
    logic        rden;
    logic        wren;
    logic [7:0]  addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_strb;

    logic [3:0]  rdy;
    logic [3:0]  erro;
    logic [3:0]  busyo;
    logic [15:0] rdv [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_memory_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) if0 ();
    param_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if1 ();
    param_memory_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) if2 ();

    assign if0.ce = ce[0];  assign if0.rden = rden;  assign if0.wren = wren;  assign if0.addr = addr;
    assign if0.wr_data = wr_data[7:0];  assign if0.wr_strb = wr_strb[0:0];
    assign if1.ce = ce[1];  assign if1.rden = rden;  assign if1.wren = wren;  assign if1.addr = addr;
    assign if1.wr_data = wr_data;       assign if1.wr_strb = wr_strb;
    assign if2.ce = ce[2];  assign if2.rden = rden;  assign if2.wren = wren;  assign if2.addr = addr;
    assign if2.wr_data = wr_data[7:0];  assign if2.wr_strb = wr_strb[0:0];

    assign rdy   = {1'b0, if2.ready, if1.ready, if0.ready};
    assign erro  = {1'b0, if2.err,   if1.err,   if0.err};
    assign busyo = {1'b0, if2.busy,  if1.busy,  if0.busy};
    assign rdv[0] = {8'h00, if0.rd_data};
    assign rdv[1] = if1.rd_data;
    assign rdv[2] = {8'h00, if2.rd_data};
    assign rdv[3] = 16'h0000;

    param_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(1), .INIT_MODE(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0), .INIT_MODE(0))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    param_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(3), .INIT_MODE(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        int          dut;
        logic        rd;
        logic        wr;
        logic [7:0]  a;
        logic [15:0] wd;
        logic [1:0]  st;
        int          lat;
        logic        er;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic xact(input int d, input logic rd, input logic wr, input logic [7:0] a,
                        input logic [15:0] wd, input logic [1:0] st,
                        output int lat, output int bcnt, output logic seen,
                        output logic e, output logic [15:0] rdo, output logic pulse_ok);
        logic [1:0] di;
        di = 2'(d);
        @(negedge clk);
        ce = 3'(1 << d); rden = rd; wren = wr; addr = a; wr_data = wd; wr_strb = st;
        @(posedge clk);
        #1;
        rden = 1'b0; wren = 1'b0; addr = ~a; wr_data = ~wd; wr_strb = ~st;
        lat = 0; bcnt = 0; seen = 1'b0; e = 1'b0; rdo = '0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busyo[di]) bcnt++;
            if (rdy[di]) begin
                seen = 1'b1;
                e    = erro[di];
                rdo  = rdv[di];
            end
        end
        @(negedge clk);
        pulse_ok = !rdy[di] && !busyo[di] && !erro[di];
        ce = '0;
    endtask

    initial begin
        int          lat, bcnt, rc;
        logic        seen, e, pok;
        logic [15:0] rdo;
        int          pulses [$];

        rst_n = 1'b0; ce = '0; rden = 1'b0; wren = 1'b0; addr = '0; wr_data = '0; wr_strb = '0;

        //            dut rd    wr    addr    wdata     strb   lat err   rd_data
        vecs[0]  = '{0, 1'b1, 1'b0, 8'h2A, 16'h0000, 2'b01, 2, 1'b0, 16'h002A};
        vecs[1]  = '{0, 1'b1, 1'b1, 8'h03, 16'h0055, 2'b01, 2, 1'b0, 16'h0003};
        vecs[2]  = '{0, 1'b1, 1'b0, 8'h03, 16'h0000, 2'b01, 2, 1'b0, 16'h0003};
        vecs[3]  = '{0, 1'b0, 1'b1, 8'h10, 16'h00C3, 2'b01, 2, 1'b0, 16'h0003};
        vecs[4]  = '{0, 1'b1, 1'b0, 8'h10, 16'h0000, 2'b01, 2, 1'b0, 16'h00C3};
        vecs[5]  = '{0, 1'b0, 1'b1, 8'h11, 16'h00FF, 2'b00, 2, 1'b0, 16'h00C3};
        vecs[6]  = '{0, 1'b1, 1'b0, 8'h11, 16'h0000, 2'b01, 2, 1'b0, 16'h0011};
        vecs[7]  = '{0, 1'b1, 1'b0, 8'hFF, 16'h0000, 2'b01, 2, 1'b0, 16'h00FF};
        vecs[8]  = '{1, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b11, 1, 1'b0, 16'h0000};
        vecs[9]  = '{1, 1'b0, 1'b1, 8'h05, 16'h1234, 2'b11, 1, 1'b0, 16'h0000};
        vecs[10] = '{1, 1'b0, 1'b1, 8'h05, 16'hABCD, 2'b10, 1, 1'b0, 16'h0000};
        vecs[11] = '{1, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b11, 1, 1'b0, 16'hAB34};
        vecs[12] = '{1, 1'b0, 1'b1, 8'h05, 16'h00EE, 2'b01, 1, 1'b0, 16'hAB34};
        vecs[13] = '{1, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b11, 1, 1'b0, 16'hABEE};
        vecs[14] = '{2, 1'b0, 1'b1, 8'd210, 16'h0077, 2'b01, 4, 1'b1, 16'h0000};
        vecs[15] = '{2, 1'b1, 1'b0, 8'd210, 16'h0000, 2'b01, 4, 1'b1, 16'h0000};
        vecs[16] = '{2, 1'b1, 1'b0, 8'd199, 16'h0000, 2'b01, 4, 1'b0, 16'h00C7};
        vecs[17] = '{2, 1'b0, 1'b1, 8'd199, 16'h005A, 2'b01, 4, 1'b0, 16'h00C7};
        vecs[18] = '{2, 1'b1, 1'b0, 8'd199, 16'h0000, 2'b01, 4, 1'b0, 16'h005A};
        vecs[19] = '{2, 1'b1, 1'b0, 8'd200, 16'h0000, 2'b01, 4, 1'b1, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ready_d%0d", d), 32'(rdy[2'(d)]),  32'd0);
            check($sformatf("rst_err_d%0d", d),   32'(erro[2'(d)]), 32'd0);
            check($sformatf("rst_busy_d%0d", d),  32'(busyo[2'(d)]), 32'd0);
            check($sformatf("rst_rdata_d%0d", d), 32'(rdv[2'(d)]),  32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            xact(vecs[i].dut, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].st,
                 lat, bcnt, seen, e, rdo, pok);
            check($sformatf("v%0d_ready_seen", i), 32'(seen), 32'd1);
            check($sformatf("v%0d_latency", i),    32'(lat),  32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
            check($sformatf("v%0d_err", i),        32'(e),    32'(vecs[i].er));
            check($sformatf("v%0d_rd_data", i),    32'(rdo),  32'(vecs[i].exp_rd));
            check($sformatf("v%0d_single_pulse", i), 32'(pok), 32'd1);
        end

        // Request held continuously on the WAIT_STATES=1 instance: a pulse every 3 cycles.
        @(negedge clk);
        ce = 3'b001; rden = 1'b1; wren = 1'b0; addr = 8'h03;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rdy[0]) pulses.push_back(k);
        end
        ce = '0; rden = 1'b0;
        check("cont_pulse_count", 32'(pulses.size()), 32'd4);
        if (pulses.size() > 0) check("cont_first_pulse", 32'(pulses[0]), 32'd2);
        for (int i = 1; i < pulses.size(); i++)
            check($sformatf("cont_gap%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd3);
        check("cont_rd_data", 32'(rdv[0]), 32'h3);

        // ce dropped two cycles into a WAIT_STATES=3 write: abort, no commit.
        @(negedge clk);
        ce = 3'b100; wren = 1'b1; rden = 1'b0; addr = 8'd7; wr_data = 16'h00EE; wr_strb = 2'b01;
        @(posedge clk);
        #1;
        wren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ce = '0;
        @(negedge clk);
        check("abort_busy", 32'(busyo[2]), 32'd0);
        check("abort_rd_data_held", 32'(rdv[2]), 32'd0);
        rc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy[2]) rc++;
        end
        check("abort_no_ready", 32'(rc), 32'd0);
        xact(2, 1'b1, 1'b0, 8'd7, 16'h0000, 2'b01, lat, bcnt, seen, e, rdo, pok);
        check("abort_mem7_kept", 32'(rdo), 32'h07);
        check("abort_read_latency", 32'(lat), 32'd4);

        // Reset pulsed while a write to addr 9 sits in WAIT.
        @(negedge clk);
        ce = 3'b001; wren = 1'b1; rden = 1'b0; addr = 8'd9; wr_data = 16'h00FF; wr_strb = 2'b01;
        @(posedge clk);
        #1;
        wren = 1'b0;
        check("midrst_busy_before", 32'(busyo[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busyo[0]), 32'd0);
        check("midrst_ready", 32'(rdy[0]), 32'd0);
        check("midrst_rd_data", 32'(rdv[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ce = '0;
        xact(0, 1'b1, 1'b0, 8'd9, 16'h0000, 2'b01, lat, bcnt, seen, e, rdo, pok);
        check("midrst_mem9_kept", 32'(rdo), 32'h09);
        check("midrst_next_latency", 32'(lat), 32'd2);
        check("midrst_next_err", 32'(e), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
